// File: rtl/result_window_accumulator_pkg.sv
// Shared types for the result statistics path: FSM state encoding and the
// statistics record layout seen by downstream consumers.
package result_stats_pkg;

    localparam int DATA_W_DEFAULT = 10;
    localparam int WINDOW_DEFAULT = 8;
    localparam int CNT_W_DEFAULT  = $clog2(WINDOW_DEFAULT + 1);
    localparam int SUM_W_DEFAULT  = DATA_W_DEFAULT + $clog2(WINDOW_DEFAULT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } acc_state_t;

    typedef struct packed {
        logic [SUM_W_DEFAULT-1:0]  sum;
        logic [DATA_W_DEFAULT-1:0] min;
        logic [DATA_W_DEFAULT-1:0] max;
        logic [CNT_W_DEFAULT-1:0]  count;
    } stats_rec_t;

endpackage

// File: rtl/result_window_accumulator_if.sv
// Sample-in / record-out handshake bundle for the window accumulator.
// slave = accumulator side, master = producer/consumer side.
interface result_window_accumulator_if #(
    parameter int DATA_W = 10,
    parameter int WINDOW = 8
);
    localparam int CNT_W = $clog2(WINDOW + 1);
    localparam int SUM_W = DATA_W + $clog2(WINDOW);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out_sum;
    logic [DATA_W-1:0] out_min;
    logic [DATA_W-1:0] out_max;
    logic [CNT_W-1:0]  out_count;

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_sum, out_min, out_max, out_count
    );

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_sum, out_min, out_max, out_count
    );
endinterface

// File: rtl/result_window_accumulator.sv
// Accumulates sum/min/max/count over WINDOW samples (or fewer on flush) and
// emits one record per window; record visible the cycle after the closing accept.
// Input stalls (in_ready low) while a record waits for out_ready.
module result_window_accumulator
    import result_stats_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int WINDOW = WINDOW_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    result_window_accumulator_if.slave  bus
);
    localparam int CNT_W = $clog2(WINDOW + 1);
    localparam int SUM_W = DATA_W + $clog2(WINDOW);

    acc_state_t        r_state;
    acc_state_t        w_next_state;

    logic [SUM_W-1:0]  r_sum;
    logic [DATA_W-1:0] r_min;
    logic [DATA_W-1:0] r_max;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_out_vld;
    logic [SUM_W-1:0]  r_out_sum;
    logic [DATA_W-1:0] r_out_min;
    logic [DATA_W-1:0] r_out_max;
    logic [CNT_W-1:0]  r_out_cnt;

    logic              w_in_rdy;
    logic              w_accept;
    logic              w_load_rec;
    logic              w_clear;
    logic [SUM_W-1:0]  w_acc_sum;
    logic [DATA_W-1:0] w_acc_min;
    logic [DATA_W-1:0] w_acc_max;
    logic [CNT_W-1:0]  w_acc_cnt;

    assign w_in_rdy = (r_state != EMIT);
    assign w_accept = bus.in_valid && w_in_rdy;

    // Running values including this cycle's sample, so a closing accept
    // lands in the record that is loaded on the same edge.
    always_comb begin
        w_acc_sum = r_sum;
        w_acc_min = r_min;
        w_acc_max = r_max;
        w_acc_cnt = r_cnt;
        if (w_accept) begin
            w_acc_sum = r_sum + SUM_W'(bus.in_data);
            w_acc_min = (bus.in_data < r_min) ? bus.in_data : r_min;
            w_acc_max = (bus.in_data > r_max) ? bus.in_data : r_max;
            w_acc_cnt = r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = bus.flush ? EMIT : ACCUM;
                end
            end
            ACCUM: begin
                if (bus.flush || (w_acc_cnt == CNT_W'(WINDOW))) begin
                    w_next_state = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_load_rec = (r_state != EMIT) && (w_next_state == EMIT);
    assign w_clear    = (r_state == EMIT) && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
            r_min <= '1;
            r_max <= '0;
            r_cnt <= '0;
        end else if (w_clear) begin
            r_sum <= '0;
            r_min <= '1;
            r_max <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_sum <= w_acc_sum;
            r_min <= w_acc_min;
            r_max <= w_acc_max;
            r_cnt <= w_acc_cnt;
        end
    end

    // Record only changes on entry to EMIT, so it is stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_out_sum <= '0;
            r_out_min <= '0;
            r_out_max <= '0;
            r_out_cnt <= '0;
        end else begin
            r_out_vld <= (w_next_state == EMIT);
            if (w_load_rec) begin
                r_out_sum <= w_acc_sum;
                r_out_min <= w_acc_min;
                r_out_max <= w_acc_max;
                r_out_cnt <= w_acc_cnt;
            end
        end
    end

    assign bus.in_ready  = w_in_rdy;
    assign bus.out_valid = r_out_vld;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_min   = r_out_min;
    assign bus.out_max   = r_out_max;
    assign bus.out_count = r_out_cnt;

endmodule

// File: tb/tb_result_window_accumulator.sv
// Directed bench for result_window_accumulator: inputs change and outputs
// are checked on the falling edge, away from the capturing rising edge.
module tb_result_window_accumulator;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    result_window_accumulator_if #(.DATA_W(10), .WINDOW(8)) bus ();

    result_window_accumulator #(.DATA_W(10), .WINDOW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [9:0] d, input logic f);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.flush    = f;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic chk_rec(input string tag, input int s, input int mn, input int mx, input int c);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".sum"},   32'(bus.out_sum),   32'(s));
        chk({tag, ".min"},   32'(bus.out_min),   32'(mn));
        chk({tag, ".max"},   32'(bus.out_max),   32'(mx));
        chk({tag, ".count"}, 32'(bus.out_count), 32'(c));
        chk({tag, ".in_rdy"}, 32'(bus.in_ready), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".sum"},   32'(bus.out_sum),   32'd0);
        chk({tag, ".min"},   32'(bus.out_min),   32'd0);
        chk({tag, ".max"},   32'(bus.out_max),   32'd0);
        chk({tag, ".count"}, 32'(bus.out_count), 32'd0);
    endtask

    initial begin
        n_total       = 0;
        n_bad         = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk_zero("reset");
        chk("reset.in_rdy", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;

        // full window 0..7
        for (int i = 0; i < 8; i++) push(10'(i), 1'b0);
        idle();
        chk_rec("full", 28, 0, 7, 8);
        @(negedge clk);
        chk("full.after_vld", 32'(bus.out_valid), 32'd0);
        chk("full.after_rdy", 32'(bus.in_ready), 32'd1);

        // widest sum, no wrap
        for (int i = 0; i < 8; i++) push(10'd1023, 1'b0);
        idle();
        chk_rec("sat", 8184, 1023, 1023, 8);

        // partial window closed by a lone flush
        push(10'd5, 1'b0);
        push(10'd1, 1'b0);
        push(10'd9, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        idle();
        chk_rec("pflush", 15, 1, 9, 3);
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("idle_flush.vld0", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("idle_flush.vld1", 32'(bus.out_valid), 32'd0);

        // flush together with the final accept
        push(10'd2, 1'b0);
        push(10'd4, 1'b0);
        push(10'd6, 1'b1);
        idle();
        chk_rec("flush_acc", 12, 2, 6, 3);
        @(negedge clk);

        // backpressure: record held, inputs ignored
        bus.out_ready = 1'b0;
        push(10'd100, 1'b0);
        push(10'd50, 1'b0);
        push(10'd75, 1'b1);
        idle();
        for (int k = 0; k < 5; k++) begin
            chk_rec($sformatf("bp%0d", k), 225, 50, 100, 3);
            bus.in_valid = 1'b1;
            bus.in_data  = 10'd999;
            bus.flush    = 1'b1;
            @(negedge clk);
        end
        chk_rec("bp_last", 225, 50, 100, 3);
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp.release_vld", 32'(bus.out_valid), 32'd0);
        push(10'd3, 1'b0);
        push(10'd4, 1'b1);
        idle();
        chk_rec("bp.next", 7, 3, 4, 2);
        @(negedge clk);

        // reset in the middle of a window
        for (int i = 0; i < 4; i++) push(10'd20, 1'b0);
        idle();
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;

        // reset while a record is pending
        bus.out_ready = 1'b0;
        push(10'd1, 1'b0);
        push(10'd2, 1'b1);
        idle();
        chk_rec("pre_rst_emit", 3, 1, 2, 2);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_emit");
        chk("rst_emit.in_rdy", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;

        for (int i = 0; i < 8; i++) push(10'd10, 1'b0);
        idle();
        chk_rec("post_rst", 80, 10, 10, 8);
        @(negedge clk);
        chk("post_rst.after_vld", 32'(bus.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
